dequant_sequencer: RTL and testbench
====================================

Name: dequant_sequencer

Overview:
Sequences 8x8 coefficient blocks, column by column, into the single-cycle-latency inverse quantizer and selects the quant table per column. Generates the quantizer's column index and luma/chroma select. Absorbs the quantizer's lack of backpressure with a credit-checked output FIFO. Sits between the entropy-decode column stream and the IDCT column input, one MCU at a time.

Parameters:
FIFO_DEPTH, 4, output FIFO entries (power of 2, min 2)
DATA_W, 96, column width (8 x 12-bit signed coefficients)
MAX_Y_BLOCKS, 4, max luma blocks per MCU

Ports:
clk_in  input  1  clock
rst_n_in  input  1  reset, asynchronous, active-low
y_blocks_in  input  3  luma blocks per MCU (1..MAX_Y_BLOCKS), sampled on MCU start
s_data_in  input  DATA_W  incoming quantized column
s_valid_in  input  1  column valid
s_ready_out  output  1  column accepted when s_valid_in && s_ready_out
dq_column_out  output  DATA_W  column to quantizer
dq_valid_out  output  1  quantizer valid_in
dq_col_idx_out  output  3  column index 0..7 within block
dq_table_sel_out  output  1  0 = luma table, 1 = chroma table
dq_column_in  input  DATA_W  quantizer result
dq_valid_in  input  1  quantizer valid_out
m_data_out  output  DATA_W  dequantized column
m_valid_out  output  1  output valid
m_ready_in  input  1  downstream ready
m_last_out  output  1  column 7 of a block
m_comp_out  output  2  0 = Y, 1 = Cb, 2 = Cr
mcu_done_out  output  1  one-cycle pulse, MCU fully drained

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all counters 0; FIFO empty; s_ready_out=0; dq_valid_out=0; m_valid_out=0; mcu_done_out=0; dq_column_out=0; dq_col_idx_out=0; dq_table_sel_out=0; m_last_out=0; m_comp_out=0.
- States:
  - IDLE: s_ready_out=0. Moves to RUN next cycle and latches y_blocks_in. A value of 0 or >MAX_Y_BLOCKS clamps to 1.
  - RUN: accepts columns.
  - DRAIN: s_ready_out=0; waits for in-flight=0 and FIFO empty.
- Credit: in_flight = dq_valid_out registered count (0/1). s_ready_out = RUN && (fifo_count + in_flight + dq_valid_out) < FIFO_DEPTH. The quantizer output therefore never finds the FIFO full.
- Issue:
  - An accepted column is registered to dq_column_out with dq_valid_out=1 on the next cycle.
  - dq_col_idx_out = col_cnt and dq_table_sel_out = (comp!=0) are registered alongside it.
  - dq_valid_out is 0 in any cycle without acceptance.
- Counters advance on acceptance:
  - col_cnt 0..7 wraps.
  - On wrap, blk_cnt increments.
  - comp = 0 while blk_cnt < Y; 1 at blk_cnt = Y; 2 at Y+1.
  - Accepting col 7 of the Cr block resets col_cnt/blk_cnt to 0 and moves to DRAIN.
- Sideband: m_last_out/m_comp_out tags travel with each column through a 1-entry delay matching quantizer latency. They are stored in the FIFO with the data.
- FIFO: written on dq_valid_in; m_valid_out = !empty; popped on m_valid_out && m_ready_in. Simultaneous push and pop keeps the count.
- A dq_valid_in with no matching issue (protocol error) is dropped when the FIFO is full, never overwriting.
- DRAIN to IDLE when FIFO empty and nothing in flight; mcu_done_out pulses on that transition cycle.
- Total latency, empty pipe, m_ready_in=1: accepted column appears on m_data_out 3 cycles after acceptance (issue reg, quantizer, FIFO reg).
- Reset mid-MCU discards all in-flight and FIFO data; counters return to 0.

Optional Feature:
SEQ_PERF_EN
- Defined: adds output stall_cnt_out[31:0], saturating. Counts cycles with s_valid_in && !s_ready_out in RUN, plus cycles with m_valid_out && !m_ready_in. Cleared only by reset.
- Undefined: port absent, no counter logic.

Test Plan:
- y_blocks_in=1, stream 24 columns, m_ready_in=1 -> 24 outputs. m_comp_out is 0 for columns 0-7, 1 for 8-15, 2 for 16-23. m_last_out is set on columns 7/15/23. Exactly one mcu_done_out pulse.
- y_blocks_in=4, 48 columns -> dq_table_sel_out=0 on the first 32 issues and 1 on the last 16. dq_col_idx_out cycles 0..7 six times.
- Single column accepted at cycle t -> dq_valid_out at t+1, m_valid_out at t+3. With a stub quantizer x*16, input 0x001 in lane 0 gives lane 0 = 0x010.
- m_ready_in=0 held, FIFO_DEPTH=4 -> exactly 4 columns accepted, then s_ready_out=0 and no FIFO overflow. Releasing m_ready_in -> all 4 emitted in order, streaming resumes.
- Assert rst_n_in low mid-block (after 5 columns) -> all outputs 0 asynchronously. The next MCU starts at col 0, comp 0.
- SEQ_PERF_EN: 10 cycles of s_valid_in=1 with a full FIFO and m_ready_in=0 -> stall_cnt_out = 20.

Source files
------------

// File: rtl/dequant_sequencer.sv
// Column sequencer for the inverse quantizer: issues one MCU of 8x8 blocks, tags columns, buffers results.
// Optional SEQ_PERF_EN adds a saturating stall counter output (stall_cnt_out).
module dequant_sequencer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_W       = 96,
    parameter int MAX_Y_BLOCKS = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [2:0]        y_blocks_in,
    input  logic [DATA_W-1:0] s_data_in,
    input  logic              s_valid_in,
    output logic              s_ready_out,
    output logic [DATA_W-1:0] dq_column_out,
    output logic              dq_valid_out,
    output logic [2:0]        dq_col_idx_out,
    output logic              dq_table_sel_out,
    input  logic [DATA_W-1:0] dq_column_in,
    input  logic              dq_valid_in,
    output logic [DATA_W-1:0] m_data_out,
    output logic              m_valid_out,
    input  logic              m_ready_in,
    output logic              m_last_out,
    output logic [1:0]        m_comp_out,
`ifdef SEQ_PERF_EN
    output logic [31:0]       stall_cnt_out,
`endif
    output logic              mcu_done_out
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nxt;

    logic [2:0]       y_lat;
    logic [2:0]       col_cnt;
    logic [3:0]       blk_cnt;
    logic [1:0]       comp;
    logic             accept;
    logic             in_flight;
    logic             drained;
    logic [TAG_W-1:0] tag_iss;
    logic [TAG_W-1:0] tag_q;
    logic [CNT_W:0]   credit_sum;

    logic [DATA_W+TAG_W-1:0] mem [FIFO_DEPTH];
    logic [DATA_W+TAG_W-1:0] head;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;

    always_comb begin
        if (blk_cnt < {1'b0, y_lat})
            comp = 2'd0;
        else if (blk_cnt == {1'b0, y_lat})
            comp = 2'd1;
        else
            comp = 2'd2;
    end

    // Credit covers the issue register and the quantizer stage, so a result always finds room.
    assign credit_sum  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, in_flight} + {{CNT_W{1'b0}}, dq_valid_out};
    assign s_ready_out = (state == RUN) && (credit_sum < (CNT_W+1)'(FIFO_DEPTH));
    assign accept      = s_valid_in && s_ready_out;
    assign drained     = fifo_empty && !in_flight && !dq_valid_out;
    assign mcu_done_out = (state == DRAIN) && drained;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     if (accept && col_cnt == 3'd7 && comp == 2'd2) state_nxt = DRAIN;
            DRAIN:   if (drained) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            y_lat   <= 3'd1;
            col_cnt <= 3'd0;
            blk_cnt <= 4'd0;
        end else begin
            if (state == IDLE)
                y_lat <= (y_blocks_in == 3'd0 || int'(y_blocks_in) > MAX_Y_BLOCKS) ? 3'd1 : y_blocks_in;
            if (accept) begin
                col_cnt <= col_cnt + 3'd1;
                if (col_cnt == 3'd7)
                    blk_cnt <= (comp == 2'd2) ? 4'd0 : blk_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dq_valid_out     <= 1'b0;
            dq_column_out    <= '0;
            dq_col_idx_out   <= 3'd0;
            dq_table_sel_out <= 1'b0;
            tag_iss          <= '0;
            tag_q            <= '0;
            in_flight        <= 1'b0;
        end else begin
            dq_valid_out <= accept;
            in_flight    <= dq_valid_out;
            tag_q        <= tag_iss;
            if (accept) begin
                dq_column_out    <= s_data_in;
                dq_col_idx_out   <= col_cnt;
                dq_table_sel_out <= (comp != 2'd0);
                tag_iss          <= {col_cnt == 3'd7, comp};
            end
        end
    end

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign push       = dq_valid_in && !fifo_full;
    assign pop        = !fifo_empty && m_ready_in;

    always_ff @(posedge clk_in) begin
        if (push)
            mem[wr_ptr] <= {tag_q, dq_column_in};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Stale storage is masked so an empty FIFO always presents zeros.
    assign head        = mem[rd_ptr];
    assign m_valid_out = !fifo_empty;
    assign m_data_out  = fifo_empty ? '0 : head[DATA_W-1:0];
    assign m_last_out  = !fifo_empty && head[DATA_W+2];
    assign m_comp_out  = fifo_empty ? 2'd0 : head[DATA_W +: 2];

`ifdef SEQ_PERF_EN
    logic [1:0]  stall_inc;
    logic [32:0] stall_sum;

    assign stall_inc = 2'(s_valid_in && !s_ready_out && state == RUN) + 2'(m_valid_out && !m_ready_in);
    assign stall_sum = {1'b0, stall_cnt_out} + {31'd0, stall_inc};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            stall_cnt_out <= 32'd0;
        else
            stall_cnt_out <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
    end
`endif

endmodule

// File: tb/tb_dequant_sequencer.sv
// Randomized bench for dequant_sequencer: stub x16 quantizer plus a queue-based column scoreboard.
module tb_dequant_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int DATA_W     = 96;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic [2:0]        y_blocks_in;
    logic [DATA_W-1:0] s_data_in;
    logic              s_valid_in;
    logic              s_ready_out;
    logic [DATA_W-1:0] dq_column_out;
    logic              dq_valid_out;
    logic [2:0]        dq_col_idx_out;
    logic              dq_table_sel_out;
    logic [DATA_W-1:0] dq_column_in;
    logic              dq_valid_in;
    logic [DATA_W-1:0] m_data_out;
    logic              m_valid_out;
    logic              m_ready_in;
    logic              m_last_out;
    logic [1:0]        m_comp_out;
    logic              mcu_done_out;
`ifdef SEQ_PERF_EN
    logic [31:0]       stall_cnt_out;
`endif

    dequant_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W), .MAX_Y_BLOCKS(4)) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .y_blocks_in(y_blocks_in),
        .s_data_in(s_data_in),
        .s_valid_in(s_valid_in),
        .s_ready_out(s_ready_out),
        .dq_column_out(dq_column_out),
        .dq_valid_out(dq_valid_out),
        .dq_col_idx_out(dq_col_idx_out),
        .dq_table_sel_out(dq_table_sel_out),
        .dq_column_in(dq_column_in),
        .dq_valid_in(dq_valid_in),
        .m_data_out(m_data_out),
        .m_valid_out(m_valid_out),
        .m_ready_in(m_ready_in),
        .m_last_out(m_last_out),
        .m_comp_out(m_comp_out),
`ifdef SEQ_PERF_EN
        .stall_cnt_out(stall_cnt_out),
`endif
        .mcu_done_out(mcu_done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic              last;
        logic [1:0]        comp;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   accepted   = 0;
    int   done_count = 0;
    int   accept_k   = 0;
    int   issue_k    = 0;
    int   y_eff      = 1;

    function automatic logic [DATA_W-1:0] scale16(input logic [DATA_W-1:0] c);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            r[i*12 +: 12] = c[i*12 +: 12] * 12'd16;
        return r;
    endfunction

    function automatic int clamp_y(input int y);
        return (y < 1 || y > 4) ? 1 : y;
    endfunction

    function automatic logic [1:0] comp_of(input int blk, input int y);
        if (blk < y)
            return 2'd0;
        else if (blk == y)
            return 2'd1;
        return 2'd2;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Stub quantizer: one-cycle latency, each 12-bit lane multiplied by 16.
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dq_valid_in  <= 1'b0;
            dq_column_in <= '0;
        end else begin
            dq_valid_in  <= dq_valid_out;
            dq_column_in <= scale16(dq_column_out);
        end
    end

    // Scoreboard: every accepted column predicts one output, tagged by its position in the MCU.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n_in) begin
            if (s_valid_in && s_ready_out) begin
                checkOutput("credit", 128'(exp_q.size() < FIFO_DEPTH), 128'(1));
                e.data = scale16(s_data_in);
                e.last = (accept_k % 8) == 7;
                e.comp = comp_of(accept_k / 8, y_eff);
                exp_q.push_back(e);
                accept_k = (accept_k + 1) % (8 * (y_eff + 2));
                accepted++;
            end
            if (dq_valid_out) begin
                checkOutput("col_idx", 128'(dq_col_idx_out), 128'(issue_k % 8));
                checkOutput("table_sel", 128'(dq_table_sel_out), 128'(comp_of(issue_k / 8, y_eff) != 2'd0));
                issue_k = (issue_k + 1) % (8 * (y_eff + 2));
            end
            if (m_valid_out && m_ready_in) begin
                checkOutput("out_present", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", 128'(m_data_out), 128'(e.data));
                    checkOutput("out_last", 128'(m_last_out), 128'(e.last));
                    checkOutput("out_comp", 128'(m_comp_out), 128'(e.comp));
                end
            end
            if (mcu_done_out)
                done_count++;
        end
    end

    task automatic applyStimulus(input int n, input int ready_pct);
        int target;
        target = accepted + n;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_in);
            #1;
            if (accepted >= target)
                break;
            s_valid_in = ($urandom_range(0, 99) < 80);
            s_data_in  = {$urandom, $urandom, $urandom};
            m_ready_in = ($urandom_range(0, 99) < ready_pct);
        end
        s_valid_in = 1'b0;
        checkOutput("stim_count", 128'(accepted >= target), 128'(1));
    endtask

    task automatic wait_ready();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_in);
            #1;
            if (s_ready_out)
                break;
        end
        checkOutput("wait_ready", 128'(s_ready_out), 128'(1));
    endtask

    task automatic wait_done(input int next_y);
        int d0;
        d0 = done_count;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk_in);
            #1;
            m_ready_in = 1'b1;
            if (done_count != d0)
                break;
        end
        y_blocks_in = 3'(next_y);
        y_eff       = clamp_y(next_y);
        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("mcu_done_pulses", 128'(done_count - d0), 128'(1));
        checkOutput("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_s_ready"}, 128'(s_ready_out), 128'(0));
        checkOutput({tag, "_dq_valid"}, 128'(dq_valid_out), 128'(0));
        checkOutput({tag, "_dq_column"}, 128'(dq_column_out), 128'(0));
        checkOutput({tag, "_dq_col_idx"}, 128'(dq_col_idx_out), 128'(0));
        checkOutput({tag, "_dq_table"}, 128'(dq_table_sel_out), 128'(0));
        checkOutput({tag, "_m_valid"}, 128'(m_valid_out), 128'(0));
        checkOutput({tag, "_m_data"}, 128'(m_data_out), 128'(0));
        checkOutput({tag, "_m_last"}, 128'(m_last_out), 128'(0));
        checkOutput({tag, "_m_comp"}, 128'(m_comp_out), 128'(0));
        checkOutput({tag, "_done"}, 128'(mcu_done_out), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dq_lat;
        int m_lat;
        int a0;
        logic [11:0] lane0;
        logic [31:0] s0;
        logic [31:0] s1;

        rst_n_in    = 1'b0;
        y_blocks_in = 3'd1;
        y_eff       = 1;
        s_valid_in  = 1'b0;
        s_data_in   = '0;
        m_ready_in  = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        rst_n_in = 1'b1;

        // Single column latency through issue, quantizer and FIFO.
        wait_ready();
        s_data_in  = 96'h1;
        s_valid_in = 1'b1;
        @(negedge clk_in);
        checkOutput("lat_accept", 128'(s_ready_out), 128'(1));
        dq_lat = 0;
        m_lat  = 0;
        lane0  = 12'h0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk_in);
            #1;
            s_valid_in = 1'b0;
            @(negedge clk_in);
            if (dq_valid_out && dq_lat == 0)
                dq_lat = i;
            if (m_valid_out && m_lat == 0) begin
                m_lat = i;
                lane0 = m_data_out[11:0];
            end
        end
        checkOutput("lat_dq_valid", 128'(dq_lat), 128'(1));
        checkOutput("lat_m_valid", 128'(m_lat), 128'(3));
        checkOutput("lat_lane0", 128'(lane0), 128'(12'h010));
        applyStimulus(23, 100);
        wait_done(4);

        // Four luma blocks with random downstream stalls.
        wait_ready();
        applyStimulus(48, 70);
        wait_done(1);

        // Downstream held off: exactly FIFO_DEPTH columns accepted, then no more.
        wait_ready();
        a0 = accepted;
        m_ready_in = 1'b0;
        s0 = 32'd0;
        for (int c = 0; c < 18; c++) begin
            s_valid_in = 1'b1;
            s_data_in  = {$urandom, $urandom, $urandom};
            @(posedge clk_in);
            #1;
`ifdef SEQ_PERF_EN
            if (c == 7)
                s0 = stall_cnt_out;
`endif
        end
        checkOutput("bp_accepted", 128'(accepted - a0), 128'(FIFO_DEPTH));
        checkOutput("bp_ready_low", 128'(s_ready_out), 128'(0));
        checkOutput("bp_m_valid", 128'(m_valid_out), 128'(1));
`ifdef SEQ_PERF_EN
        s1 = stall_cnt_out;
        checkOutput("stall_count", 128'(s1 - s0), 128'(20));
`else
        s1 = s0;
`endif
        s_valid_in = 1'b0;
        m_ready_in = 1'b1;
        applyStimulus(24 - FIFO_DEPTH, 100);
        wait_done(2);

        // Asynchronous reset in the middle of a block.
        wait_ready();
        applyStimulus(5, 50);
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        accept_k = 0;
        issue_k  = 0;
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        wait_ready();
        applyStimulus(32, 80);
        wait_done(0);

        // Out-of-range block counts clamp to one luma block.
        wait_ready();
        applyStimulus(24, 60);
        wait_done(7);
        wait_ready();
        applyStimulus(24, 90);
        wait_done(3);

        for (int m = 0; m < 4; m++) begin
            int ny;
            ny = $urandom_range(0, 7);
            wait_ready();
            applyStimulus(8 * (y_eff + 2), $urandom_range(30, 100));
            wait_done(ny);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
